// File: rtl/rle_decoder.sv
// Run-length decompressor: reads (count,value) byte pairs over SRAM port A and
// writes the expanded bytes back packed 4 per word. Optional `err` output under RLE_DECODER_ERR_EN.
module rle_decoder #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       rle_addr,
  input  logic [31:0]       rle_size,
  input  logic [31:0]       message_addr,
  output logic [31:0]       message_size,
  output logic              done,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out
`ifdef RLE_DECODER_ERR_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, EXPAND, WR, FLUSH, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       rle_left;
  logic [31:0]       in_word;
  logic [1:0]        in_idx;
  logic              in_empty;
  logic              is_val;
  logic [7:0]        cnt_q;
  logic [7:0]        val_q;
  logic [7:0]        rep;
  logic [31:0]       out_word;
  logic [1:0]        out_cnt;
  logic [31:0]       out_next;
  logic [7:0]        in_byte;

  assign port_A_clk = clk;

  logic unused_ok;
  assign unused_ok = ^{rle_addr[31:ADDR_W], message_addr[31:ADDR_W]};

  always_comb begin
    out_next = out_word;
    out_next[{out_cnt, 3'b000} +: 8] = val_q;
    in_byte = in_word[{in_idx, 3'b000} +: 8];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state          <= IDLE;
      done           <= 1'b0;
      message_size   <= '0;
      port_A_we      <= 1'b0;
      port_A_addr    <= '0;
      port_A_data_in <= '0;
      rd_addr        <= '0;
      wr_addr        <= '0;
      rle_left       <= '0;
      in_word        <= '0;
      in_idx         <= '0;
      in_empty       <= 1'b1;
      is_val         <= 1'b0;
      cnt_q          <= '0;
      val_q          <= '0;
      rep            <= '0;
      out_word       <= '0;
      out_cnt        <= '0;
`ifdef RLE_DECODER_ERR_EN
      err            <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rd_addr      <= {rle_addr[ADDR_W-1:2], 2'b00};
            wr_addr      <= {message_addr[ADDR_W-1:2], 2'b00};
            rle_left     <= rle_size;
            message_size <= '0;
            out_word     <= '0;
            out_cnt      <= '0;
            rep          <= '0;
            is_val       <= 1'b0;
            in_empty     <= 1'b1;
            in_idx       <= '0;
`ifdef RLE_DECODER_ERR_EN
            err          <= rle_size[0];
`endif
            if (rle_size == 32'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              done        <= 1'b0;
              port_A_we   <= 1'b0;
              port_A_addr <= {rle_addr[ADDR_W-1:2], 2'b00};
              state       <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          rd_addr <= rd_addr + ADDR_W'(4);
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          in_word  <= port_A_data_out;
          in_idx   <= '0;
          in_empty <= 1'b0;
          state    <= EXPAND;
        end
        EXPAND: begin
          if (rep != 8'd0) begin
            // One output byte per cycle; the 4th byte launches the word write.
            out_word <= out_next;
            out_cnt  <= out_cnt + 2'd1;
            rep      <= rep - 8'd1;
            if (message_size != 32'hFFFF_FFFF)
              message_size <= message_size + 32'd1;
            if (out_cnt == 2'd3) begin
              port_A_we      <= 1'b1;
              port_A_addr    <= wr_addr;
              port_A_data_in <= out_next;
              state          <= WR;
            end
          end else if (rle_left == 32'd0) begin
            if (out_cnt != 2'd0) begin
              port_A_we      <= 1'b1;
              port_A_addr    <= wr_addr;
              port_A_data_in <= out_word;
            end
            state <= FLUSH;
          end else if (in_empty) begin
            port_A_we   <= 1'b0;
            port_A_addr <= rd_addr;
            state       <= RD_REQ;
          end else begin
            // Consume one compressed byte; a trailing count byte is simply dropped.
            if (is_val) begin
              val_q <= in_byte;
              rep   <= cnt_q;
`ifdef RLE_DECODER_ERR_EN
              if (cnt_q == 8'd0) err <= 1'b1;
`endif
            end else begin
              cnt_q <= in_byte;
            end
            is_val   <= ~is_val;
            in_idx   <= in_idx + 2'd1;
            rle_left <= rle_left - 32'd1;
            if (in_idx == 2'd3) in_empty <= 1'b1;
          end
        end
        WR: begin
          port_A_we <= 1'b0;
          wr_addr   <= wr_addr + ADDR_W'(4);
          out_word  <= '0;
          out_cnt   <= '0;
          state     <= EXPAND;
        end
        FLUSH: begin
          port_A_we <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_decoder.sv
// Directed bench for rle_decoder: word-addressed SRAM model with 1-cycle read
// latency, write log, and hand-computed expected outputs.
module tb_rle_decoder;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] rle_addr = '0, rle_size = '0, message_addr = '0;
  logic [31:0] message_size;
  logic        done;
  logic        port_A_clk;
  logic [15:0] port_A_addr;
  logic        port_A_we;
  logic [31:0] port_A_data_in;
  logic [31:0] port_A_data_out;
`ifdef RLE_DECODER_ERR_EN
  logic        err;
`endif

  rle_decoder #(.ADDR_W(16)) dut (
    .clk(clk), .nreset(nreset), .start(start),
    .rle_addr(rle_addr), .rle_size(rle_size), .message_addr(message_addr),
    .message_size(message_size), .done(done), .port_A_clk(port_A_clk),
    .port_A_addr(port_A_addr), .port_A_we(port_A_we),
    .port_A_data_in(port_A_data_in), .port_A_data_out(port_A_data_out)
`ifdef RLE_DECODER_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  logic [15:0] wlog_a [0:511];
  logic [31:0] wlog_d [0:511];
  int          wr_cnt = 0;
  int          cyc = 0;
  int          last_we = 0;
  int          vectors = 0;
  int          errors = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    port_A_data_out <= mem[port_A_addr[15:2]];
    if (port_A_we) begin
      mem[port_A_addr[15:2]] <= port_A_data_in;
      if (wr_cnt < 512) begin
        wlog_a[wr_cnt] <= port_A_addr;
        wlog_d[wr_cnt] <= port_A_data_in;
      end
      wr_cnt  <= wr_cnt + 1;
      last_we <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] ma);
    @(negedge clk);
    rle_addr = ra; rle_size = rs; message_addr = ma; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] ra, input logic [31:0] rs,
                     input logic [31:0] ma);
    int n;
    kick(ra, rs, ma);
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  int base;
  int good;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    #1;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_size", message_size, 32'd0);
    chk("rst_we", {31'd0, port_A_we}, 32'd0);
    chk("rst_addr", {16'd0, port_A_addr}, 32'd0);
    chk("rst_data", port_A_data_in, 32'd0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;

    // T1: 3 x 'A' -> one partial word
    mem[16'h0100 >> 2] = 32'h0000_4103;
    base = wr_cnt;
    run("t1", 32'h0100, 32'd2, 32'h0200);
    chk("t1_nwr", wr_cnt - base, 32'd1);
    chk("t1_waddr", {16'd0, wlog_a[base]}, 32'h0200);
    chk("t1_wdata", wlog_d[base], 32'h0041_4141);
    chk("t1_size", message_size, 32'd3);
    chk("t1_done_lat", cyc, last_we + 1);
`ifdef RLE_DECODER_ERR_EN
    chk("t1_err", {31'd0, err}, 32'd0);
`endif

    // T2: two exact words, no flush write
    mem[16'h0104 >> 2] = 32'h4204_4104;
    base = wr_cnt;
    run("t2", 32'h0104, 32'd4, 32'h0300);
    chk("t2_nwr", wr_cnt - base, 32'd2);
    chk("t2_wd0", wlog_d[base], 32'h4141_4141);
    chk("t2_wd1", wlog_d[base+1], 32'h4242_4242);
    chk("t2_wa1", {16'd0, wlog_a[base+1]}, 32'h0304);
    chk("t2_size", message_size, 32'd8);

    // T3: count 255 over many output words
    mem[16'h0110 >> 2] = 32'h0000_5AFF;
    base = wr_cnt;
    run("t3", 32'h0110, 32'd2, 32'h1000);
    chk("t3_nwr", wr_cnt - base, 32'd64);
    good = 0;
    for (int i = 0; i < 63; i++) if (mem[(16'h1000 >> 2) + i] === 32'h5A5A_5A5A) good++;
    chk("t3_full", good, 32'd63);
    chk("t3_last", mem[(16'h1000 >> 2) + 63], 32'h005A_5A5A);
    chk("t3_laddr", {16'd0, wlog_a[base+63]}, 32'h10FC);
    chk("t3_size", message_size, 32'd255);

    // T4: empty stream, done one cycle after start
    base = wr_cnt;
    kick(32'h0100, 32'd0, 32'h0400);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_size", message_size, 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_nwr", wr_cnt - base, 32'd0);

    // T5: zero count discarded
    mem[16'h0120 >> 2] = 32'h3302_7700;
    base = wr_cnt;
    run("t5", 32'h0120, 32'd4, 32'h0500);
    chk("t5_nwr", wr_cnt - base, 32'd1);
    chk("t5_wdata", wlog_d[base], 32'h0000_3333);
    chk("t5_size", message_size, 32'd2);
`ifdef RLE_DECODER_ERR_EN
    chk("t5_err", {31'd0, err}, 32'd1);
`endif

    // T6: odd size, dangling count dropped
    mem[16'h0130 >> 2] = 32'h0005_6102;
    base = wr_cnt;
    run("t6", 32'h0130, 32'd3, 32'h0600);
    chk("t6_nwr", wr_cnt - base, 32'd1);
    chk("t6_wdata", wlog_d[base], 32'h0000_6161);
    chk("t6_size", message_size, 32'd2);
`ifdef RLE_DECODER_ERR_EN
    chk("t6_err", {31'd0, err}, 32'd1);
`endif

    // T7: pairs straddling an input word boundary
    mem[16'h0140 >> 2] = 32'h4401_4302;
    mem[16'h0144 >> 2] = 32'h0000_4503;
    base = wr_cnt;
    run("t7", 32'h0140, 32'd6, 32'h0700);
    chk("t7_nwr", wr_cnt - base, 32'd2);
    chk("t7_wd0", wlog_d[base], 32'h4544_4343);
    chk("t7_wd1", wlog_d[base+1], 32'h0000_4545);
    chk("t7_wa1", {16'd0, wlog_a[base+1]}, 32'h0704);
    chk("t7_size", message_size, 32'd6);

    // T8: reset in the middle of a long expansion, then decode again
    kick(32'h0110, 32'd2, 32'h2000);
    repeat (30) @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("t8_done", {31'd0, done}, 32'd0);
    chk("t8_size", message_size, 32'd0);
    chk("t8_we", {31'd0, port_A_we}, 32'd0);
    chk("t8_addr", {16'd0, port_A_addr}, 32'd0);
    chk("t8_data", port_A_data_in, 32'd0);
    base = wr_cnt;
    repeat (3) @(negedge clk);
    chk("t8_nowr", wr_cnt - base, 32'd0);
    nreset = 1'b1;
    base = wr_cnt;
    run("t8r", 32'h0100, 32'd2, 32'h0800);
    chk("t8r_nwr", wr_cnt - base, 32'd1);
    chk("t8r_wdata", wlog_d[base], 32'h0041_4141);
    chk("t8r_size", message_size, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
